// File: rtl/tagged_mem.sv
// Word memory with per-word tag, auto-incrementing address pointer and control
// registers at the top three addresses. Optional SEC-DED protection: TAGGED_MEM_ECC_EN.
module tagged_mem #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 8,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_ad,
   input  logic [TAG_W-1:0]  i_tag,
   input  logic              i_astb,
   input  logic              i_atomic,
   input  logic              i_rd,
   input  logic              i_wr,
   output logic [DATA_W-1:0] o_data,
   output logic [TAG_W-1:0]  o_tag,
   output logic              o_valid
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_SYND  = '1;
   localparam logic [ADDR_W-1:0] ADDR_LATCH = ADDR_SYND - ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_MODE  = ADDR_SYND - ADDR_W'(2);

`ifdef TAGGED_MEM_ECC_EN
   localparam int WORD_W = DATA_W + TAG_W;

   function automatic int calc_hamming_r(input int k);
      int r;
      r = 0;
      for (int i = 1; i < 31; i++) begin
         if (r == 0 && (1 << i) >= (k + i + 1)) r = i;
      end
      return r;
   endfunction

   localparam int HAM_R  = calc_hamming_r(WORD_W);
   localparam int SYND_W = HAM_R + 1;

   // Data bits occupy the non-power-of-two codeword positions starting at 3.
   function automatic logic [HAM_R-1:0] hamming_parity(input logic [WORD_W-1:0] w);
      logic [HAM_R-1:0] p;
      int pos;
      p   = '0;
      pos = 3;
      for (int i = 0; i < WORD_W; i++) begin
         if ((pos & (pos - 1)) == 0) pos = pos + 1;
         for (int j = 0; j < HAM_R; j++) begin
            if (pos[j]) p[j] = p[j] ^ w[i];
         end
         pos = pos + 1;
      end
      return p;
   endfunction

   function automatic logic [WORD_W-1:0] hamming_correct(input logic [WORD_W-1:0] w,
                                                         input logic [HAM_R-1:0]  s);
      logic [WORD_W-1:0] f;
      int pos;
      f   = w;
      pos = 3;
      for (int i = 0; i < WORD_W; i++) begin
         if ((pos & (pos - 1)) == 0) pos = pos + 1;
         if (pos == int'(s)) f[i] = ~f[i];
         pos = pos + 1;
      end
      return f;
   endfunction
`else
   localparam int SYND_W = 1;
`endif

   typedef enum logic [1:0] {OP_NONE, OP_ADDR, OP_WRITE, OP_READ} op_e;

   logic [DATA_W-1:0] mem     [DEPTH];
   logic [TAG_W-1:0]  tag_mem [DEPTH];

   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [ADDR_W-1:0] laddr_q, laddr_d;
   logic [1:0]        mode_q, mode_d;
   logic [SYND_W-1:0] synd_q, synd_d;
   logic [DATA_W-1:0] o_data_q, o_data_d;
   logic [TAG_W-1:0]  o_tag_q, o_tag_d;
   logic              o_valid_q, o_valid_d;

   op_e               op;
   logic              is_ram;
   logic              ram_we;
   logic [DATA_W-1:0] rd_data;
   logic [TAG_W-1:0]  rd_tag;

`ifdef TAGGED_MEM_ECC_EN
   logic [SYND_W-1:0] chk_mem [DEPTH];
   logic [WORD_W-1:0] rd_word, fix_word;
   logic [SYND_W-1:0] rd_chk, rd_synd, wr_chk;
   logic [HAM_R-1:0]  wr_par;

   // Syndrome is {overall parity error, Hamming position}; check bit 0 is the injection target.
   always_comb begin
      rd_word  = {tag_mem[waddr_q], mem[waddr_q]};
      rd_chk   = chk_mem[waddr_q];
      rd_synd  = {^{rd_word, rd_chk}, hamming_parity(rd_word) ^ rd_chk[HAM_R-1:0]};
      fix_word = rd_word;
      if (mode_q[0] && rd_synd[HAM_R]) begin
         fix_word = hamming_correct(rd_word, rd_synd[HAM_R-1:0]);
      end
      rd_data  = fix_word[DATA_W-1:0];
      rd_tag   = fix_word[WORD_W-1:DATA_W];
      wr_par   = hamming_parity({i_tag, i_ad});
      wr_chk   = {^{i_tag, i_ad, wr_par}, wr_par};
      if (mode_q[1]) wr_chk[0] = ~wr_chk[0];
   end
`else
   always_comb begin
      rd_data = mem[waddr_q];
      rd_tag  = tag_mem[waddr_q];
   end
`endif

   always_comb begin
      op = OP_NONE;
      if (reset) begin
         if (i_astb)    op = OP_ADDR;
         else if (i_wr) op = OP_WRITE;
         else if (i_rd) op = OP_READ;
      end
   end

   assign is_ram = (waddr_q < ADDR_MODE);

   always_comb begin
      waddr_d   = waddr_q;
      laddr_d   = laddr_q;
      mode_d    = mode_q;
      synd_d    = synd_q;
      o_data_d  = o_data_q;
      o_tag_d   = o_tag_q;
      o_valid_d = 1'b0;
      ram_we    = 1'b0;
      case (op)
         OP_ADDR: begin
            laddr_d = waddr_q;
            waddr_d = i_ad[ADDR_W-1:0];
         end
         OP_WRITE: begin
            if (is_ram) begin
               ram_we = 1'b1;
               if (!i_atomic) waddr_d = waddr_q + ADDR_W'(1);
            end else if (waddr_q == ADDR_MODE) begin
               mode_d = i_ad[1:0];
            end else if (waddr_q == ADDR_SYND) begin
               synd_d = '0;
            end
         end
         OP_READ: begin
            o_valid_d = 1'b1;
            if (is_ram) begin
               o_data_d = rd_data;
               o_tag_d  = rd_tag;
`ifdef TAGGED_MEM_ECC_EN
               if (rd_synd != '0) synd_d = rd_synd;
`endif
               if (!i_atomic) waddr_d = waddr_q + ADDR_W'(1);
            end else begin
               o_tag_d = '0;
               if (waddr_q == ADDR_SYND)       o_data_d = DATA_W'(synd_q);
               else if (waddr_q == ADDR_LATCH) o_data_d = DATA_W'(laddr_q);
               else                            o_data_d = DATA_W'(mode_q);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         waddr_q   <= '0;
         laddr_q   <= '0;
         mode_q    <= '0;
         synd_q    <= '0;
         o_data_q  <= '0;
         o_tag_q   <= '0;
         o_valid_q <= 1'b0;
      end else begin
         waddr_q   <= waddr_d;
         laddr_q   <= laddr_d;
         mode_q    <= mode_d;
         synd_q    <= synd_d;
         o_data_q  <= o_data_d;
         o_tag_q   <= o_tag_d;
         o_valid_q <= o_valid_d;
      end
   end

   // Storage is deliberately outside reset so contents survive it.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[waddr_q]     <= i_ad;
         tag_mem[waddr_q] <= i_tag;
`ifdef TAGGED_MEM_ECC_EN
         chk_mem[waddr_q] <= wr_chk;
`endif
      end
   end

   assign o_data  = o_data_q;
   assign o_tag   = o_tag_q;
   assign o_valid = o_valid_q;

endmodule

// File: tb/tb_tagged_mem.sv
// Scoreboard bench for tagged_mem: a transaction-level model predicts read results,
// a monitor compares them each cycle. Also covers the TAGGED_MEM_ECC_EN build.
module tb_tagged_mem;

   localparam int DW = 64;
   localparam int TW = 8;
   localparam int AW = 20;
   localparam int DEPTH = 2 ** AW;
   localparam int TOP = DEPTH - 1;

   typedef struct {
      logic [DW-1:0] data;
      logic [TW-1:0] tag;
      int            kind;   // 0 exact, 1 data must be nonzero, 2 data unknown
   } exp_t;

   logic          clk;
   logic          reset;
   logic [DW-1:0] i_ad;
   logic [TW-1:0] i_tag;
   logic          i_astb, i_atomic, i_rd, i_wr;
   logic [DW-1:0] o_data;
   logic [TW-1:0] o_tag;
   logic          o_valid;

   int   nChecks = 0;
   int   nFails  = 0;
   bit   monEn   = 0;
   exp_t expQ[$];

   int            waddrM, laddrM;
   logic [1:0]    modeM;
   bit            syndSetM;
   logic [DW-1:0] dataM [int];
   logic [TW-1:0] tagM [int];
   bit            corruptM [int];

   tagged_mem #(.DATA_W(DW), .TAG_W(TW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
      .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr),
      .o_data(o_data), .o_tag(o_tag), .o_valid(o_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference behaviour of one accepted clock edge, in terms of addresses and words.
   task automatic modelStep(input bit rstN, input bit astb, input bit wr, input bit rd,
                            input bit atomic, input logic [DW-1:0] ad, input logic [TW-1:0] tg);
      exp_t e;
      if (!rstN) begin
         waddrM = 0; laddrM = 0; modeM = 2'b00; syndSetM = 0;
      end else if (astb) begin
         laddrM = waddrM;
         waddrM = int'(ad[AW-1:0]);
      end else if (wr) begin
         if (waddrM <= TOP - 3) begin
            dataM[waddrM] = ad;
            tagM[waddrM]  = tg;
`ifdef TAGGED_MEM_ECC_EN
            corruptM[waddrM] = modeM[1];
`else
            corruptM[waddrM] = 0;
`endif
            if (!atomic) waddrM = (waddrM + 1) % DEPTH;
         end else if (waddrM == TOP - 2) begin
            modeM = ad[1:0];
         end else if (waddrM == TOP) begin
            syndSetM = 0;
         end
      end else if (rd) begin
         e.tag = '0; e.data = '0; e.kind = 0;
         if (waddrM <= TOP - 3) begin
            if (dataM.exists(waddrM)) begin
               e.data = dataM[waddrM];
               e.tag  = tagM[waddrM];
`ifdef TAGGED_MEM_ECC_EN
               if (corruptM[waddrM]) syndSetM = 1;
`endif
            end else begin
               e.kind = 2;
            end
            if (!atomic) waddrM = (waddrM + 1) % DEPTH;
         end else if (waddrM == TOP) begin
            e.kind = syndSetM ? 1 : 0;
         end else if (waddrM == TOP - 1) begin
            e.data = DW'(laddrM);
         end else begin
            e.data = DW'(modeM);
         end
         expQ.push_back(e);
      end
   endtask

   // Called #1 after a rising edge; drives one cycle, updates the model at the edge.
   task automatic applyStimulus(input bit rstN, input bit astb, input bit wr, input bit rd,
                                input bit atomic, input logic [DW-1:0] ad, input logic [TW-1:0] tg);
      reset = rstN; i_astb = astb; i_wr = wr; i_rd = rd; i_atomic = atomic; i_ad = ad; i_tag = tg;
      @(posedge clk);
      modelStep(rstN, astb, wr, rd, atomic, ad, tg);
      #1;
      reset = 1'b1; i_astb = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_atomic = 1'b0;
   endtask

   task automatic doAstb(input logic [DW-1:0] a);
      applyStimulus(1, 1, 0, 0, 0, a, '0);
   endtask

   task automatic doWr(input logic [DW-1:0] d, input logic [TW-1:0] t, input bit at);
      applyStimulus(1, 0, 1, 0, at, d, t);
   endtask

   task automatic doRd(input bit at);
      applyStimulus(1, 0, 0, 1, at, '0, '0);
   endtask

   // Monitor: every cycle o_valid must match whether a result is due, and results arrive in order.
   always @(negedge clk) begin
      exp_t e;
      if (monEn) begin
         nChecks++;
         if (o_valid !== (expQ.size() > 0)) begin
            nFails++;
            $display("[TB] FAIL o_valid: got %b, expected %b at %0t", o_valid, expQ.size() > 0, $time);
            if (expQ.size() > 0) void'(expQ.pop_front());
         end else if (o_valid) begin
            e = expQ.pop_front();
            if (e.kind == 0) begin
               checkOutput("rd_data", o_data, e.data);
               checkOutput("rd_tag", DW'(o_tag), DW'(e.tag));
            end else if (e.kind == 1) begin
               nChecks++;
               if (o_data == '0) begin
                  nFails++;
                  $display("[TB] FAIL synd_nonzero: got 0x%0h, expected nonzero at %0t", o_data, $time);
               end
            end
         end
      end
   end

   initial begin
      int            sel;
      logic [DW-1:0] ad;
      logic [TW-1:0] tg;
      bit            at, rdOk;

      reset = 1'b0; i_astb = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_atomic = 1'b0; i_ad = '0; i_tag = '0;
      waddrM = 0; laddrM = 0; modeM = 2'b00; syndSetM = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_o_valid", DW'(o_valid), '0);
      checkOutput("reset_o_data", o_data, '0);
      checkOutput("reset_o_tag", DW'(o_tag), '0);
      reset = 1'b1;
      monEn = 1;

      // Randomised traffic around a preloaded pool, with mode kept at zero.
      doAstb(DW'(32'h40));
      for (int i = 0; i < 16; i++) doWr({$urandom, $urandom}, TW'($urandom), 0);
      for (int n = 0; n < 400; n++) begin
         sel  = int'($urandom_range(0, 9));
         ad   = {$urandom, $urandom};
         tg   = TW'($urandom);
         at   = ($urandom_range(0, 3) == 0);
         rdOk = (waddrM > TOP - 3) || dataM.exists(waddrM);
         if (sel <= 1) begin
            ad[AW-1:0] = AW'(32'h40 + $urandom_range(0, 15));
            applyStimulus(1, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, at, ad, tg);
         end else if (sel == 2) begin
            ad[AW-1:0] = AW'(TOP - int'($urandom_range(0, 2)));
            doAstb(ad);
         end else if ((sel <= 5 && waddrM <= TOP - 3) || !rdOk) begin
            applyStimulus(1, 0, 1, $urandom_range(0, 1) == 1, at, ad, tg);
         end else begin
            doRd(at);
         end
      end

      // Burst write then burst read back.
      doAstb(DW'(32'h100)); doWr(DW'(8'hA5), 8'd3, 0); doWr(DW'(8'h5A), 8'd4, 0);
      doAstb(DW'(32'h100)); doRd(0); doRd(0);

      // Read-modify-write on one word.
      doAstb(DW'(32'h200)); doWr(DW'(8'h11), 8'd1, 0);
      doAstb(DW'(32'h200)); doRd(1); doWr(DW'(8'h77), 8'd2, 1); doRd(0);

      // Address latch and mode register.
      doAstb(DW'(32'h123)); doAstb(DW'(32'hFFFFE)); doRd(0);
      doAstb(DW'(32'hFFFFD)); doWr(DW'(3), 8'd0, 0); doRd(0);

      // Burst walks from the last RAM word into the mode register and stops there.
      doAstb(DW'(32'hFFFFC)); doWr(DW'(16'hDEAD), 8'd9, 0); doWr(DW'(1), 8'd0, 0); doRd(0);
      doAstb(DW'(32'hFFFFC)); doRd(0); doWr(DW'(0), 8'd0, 0); doRd(0);

      // Priority: address strobe beats write and read; write beats read.
      doAstb(DW'(32'h310)); doWr(DW'(8'h55), 8'd5, 0); doWr(DW'(8'h66), 8'd6, 0);
      doAstb(DW'(32'h311));
      applyStimulus(1, 1, 1, 1, 0, DW'(32'h310), 8'd7);
      doAstb(DW'(32'h311)); doRd(0);
      applyStimulus(1, 0, 1, 1, 0, DW'(8'h99), 8'd8);
      doAstb(DW'(32'h311)); doRd(0); doAstb(DW'(32'h310)); doRd(0);

      // Reset in the middle of a read burst.
      doAstb(DW'(32'hFFFFD)); doWr(DW'(2), 8'd0, 0);
      doAstb(DW'(32'h100)); doRd(0);
      applyStimulus(0, 0, 0, 1, 0, '0, '0);
      checkOutput("midreset_o_valid", DW'(o_valid), '0);
      checkOutput("midreset_o_data", o_data, '0);
      doAstb(DW'(32'hFFFFE)); doRd(0);
      doAstb(DW'(32'hFFFFD)); doRd(0);
      doAstb(DW'(32'hFFFFF)); doRd(0);

`ifdef TAGGED_MEM_ECC_EN
      // Inject a check-bit error, read it back corrected, then clear the syndrome.
      doAstb(DW'(32'hFFFFF)); doWr('0, '0, 0);
      doAstb(DW'(32'hFFFFD)); doWr(DW'(2), 8'd0, 0);
      doAstb(DW'(32'h600)); doWr(DW'(1), 8'd5, 0);
      doAstb(DW'(32'hFFFFD)); doWr(DW'(1), 8'd0, 0);
      doAstb(DW'(32'h600)); doRd(0);
      doAstb(DW'(32'hFFFFF)); doRd(0); doWr('0, '0, 0); doRd(0);
`endif

      repeat (3) applyStimulus(1, 0, 0, 0, 0, '0, '0);
      checkOutput("scoreboard_drained", DW'(expQ.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
